// File: rtl/tdm_demux_1x4.sv
// Receive-side TDM de-interleaver: splits a 4-slot serial stream back onto four
// registered channel outputs and tracks frame alignment with a HUNT/LOCKED FSM.
module tdm_demux_1x4 #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [WIDTH-1:0]     dout0,
  output logic [WIDTH-1:0]     dout1,
  output logic [WIDTH-1:0]     dout2,
  output logic [WIDTH-1:0]     dout3,
  output logic [3:0]           dout_valid,
  output logic [4*WIDTH-1:0]   frame_data,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] hold0, hold1, hold2;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 2'd0;
      hold0      <= '0;
      hold1      <= '0;
      hold2      <= '0;
      dout0      <= '0;
      dout1      <= '0;
      dout2      <= '0;
      dout3      <= '0;
      dout_valid <= '0;
      frame_data <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised below; using
      // non-blocking assignments lets the later branch win without ordering hazards.
      dout_valid <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;

      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              dout0      <= din;
              hold0      <= din;
              dout_valid <= 4'b0001;
              slot       <= 2'd1;
              state      <= LOCKED;
            end
          end

          LOCKED: begin
            if (frame_sync && slot != 2'd0) begin
              // Resync: restart the frame at this sample; partial frame is abandoned.
              sync_err   <= 1'b1;
              dout0      <= din;
              hold0      <= din;
              dout_valid <= 4'b0001;
              slot       <= 2'd1;
            end else if (!frame_sync && slot == 2'd0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end else begin
              case (slot)
                2'd0: begin dout0 <= din; hold0 <= din; end
                2'd1: begin dout1 <= din; hold1 <= din; end
                2'd2: begin dout2 <= din; hold2 <= din; end
                default: begin
                  dout3      <= din;
                  frame_data <= {din, hold2, hold1, hold0};
                  frame_done <= 1'b1;
                end
              endcase
              dout_valid <= 4'b0001 << slot;
              slot       <= slot + 2'd1;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
